// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 encryption sequencer.
package ascon_pack;

    localparam int ROUND_A = 12;
    localparam int ROUND_B = 6;
    localparam logic [63:0] ASCON_IV = 64'h80400c0600000000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        AD_WAIT,
        AD_PERM,
        PT_WAIT,
        PT_PERM,
        FINAL,
        TAG
    } type_fsm;

endpackage

// File: rtl/ascon_round_cnt.sv
// Round index counter: preloads the first round of p^a or p^b, then counts
// loaded rounds and holds at the last round index.
module ascon_round_cnt #(
    parameter logic [3:0] LOAD_B = 4'd6,
    parameter logic [3:0] LAST   = 4'd11
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       init_a_i,
    input  logic       init_b_i,
    input  logic       en_i,
    output logic [3:0] round_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (init_a_i) begin
            cnt_d = 4'd0;
        end else if (init_b_i) begin
            cnt_d = LOAD_B;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign round_o = cnt_q;

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// ASCON-128 encryption controller: one permutation round per clock through
// init, associated data, plaintext, finalisation and tag output.
//
// state   | meaning
// IDLE    | waiting for start_i
// INIT    | p^a rounds 0..11 on IV||K||N
// AD_WAIT | round 6 of p^b, waiting for an AD block
// AD_PERM | p^b rounds 7..11 after an AD block
// PT_WAIT | waiting for a PT block (round 6, or round 0 of p^a if last)
// PT_PERM | p^b rounds 7..11 after a non-last PT block
// FINAL   | p^a rounds 1..11
// TAG     | tag valid for one cycle
module ascon_fsm_ctrl
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = ROUND_A,
    parameter int ROUNDS_B = ROUND_B,
    parameter int CNT_W    = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] nb_ad_i,
    input  logic [CNT_W-1:0] nb_pt_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [3:0]       round_o,
    output logic             init_state_o,
    output logic             en_reg_state_o,
    output logic             en_xor_data_o,
    output logic             en_xor_begin_key_o,
    output logic             en_xor_end_key_o,
    output logic             en_xor_lsb_o,
    output logic             en_cipher_o,
    output logic             en_tag_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [3:0] LAST_RND = 4'(ROUNDS_A - 1);
    localparam logic [3:0] LOAD_B   = 4'(ROUNDS_A - ROUNDS_B);

    type_fsm          state_q, state_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic             cnt_init_a, cnt_init_b, cnt_en;
    logic             round_last, ad_last, pt_last;

    ascon_round_cnt #(
        .LOAD_B (LOAD_B),
        .LAST   (LAST_RND)
    ) u_round_cnt (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .init_a_i (cnt_init_a),
        .init_b_i (cnt_init_b),
        .en_i     (cnt_en),
        .round_o  (round_o)
    );

    assign round_last = (round_o == LAST_RND);
    assign ad_last    = (ad_cnt_q == CNT_W'(1));
    assign pt_last    = (pt_cnt_q == CNT_W'(1));
    assign busy_o     = (state_q != IDLE);

    always_comb begin
        state_d            = state_q;
        ad_cnt_d           = ad_cnt_q;
        pt_cnt_d           = pt_cnt_q;
        cnt_init_a         = 1'b0;
        cnt_init_b         = 1'b0;
        cnt_en             = 1'b0;
        data_ready_o       = 1'b0;
        init_state_o       = 1'b0;
        en_reg_state_o     = 1'b0;
        en_xor_data_o      = 1'b0;
        en_xor_begin_key_o = 1'b0;
        en_xor_end_key_o   = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_cipher_o        = 1'b0;
        en_tag_o           = 1'b0;
        done_o             = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = INIT;
                    ad_cnt_d   = nb_ad_i;
                    pt_cnt_d   = (nb_pt_i == '0) ? CNT_W'(1) : nb_pt_i;
                    cnt_init_a = 1'b1;
                end
            end
            INIT: begin
                en_reg_state_o = 1'b1;
                cnt_en         = 1'b1;
                init_state_o   = (round_o == 4'd0);
                if (round_last) begin
                    en_xor_end_key_o = 1'b1;
                    if (ad_cnt_q != '0) begin
                        state_d    = AD_WAIT;
                        cnt_init_b = 1'b1;
                    end else begin
                        en_xor_lsb_o = 1'b1;
                        state_d      = PT_WAIT;
                        cnt_init_a   = pt_last;
                        cnt_init_b   = !pt_last;
                    end
                end
            end
            AD_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_o  = 1'b1;
                    en_reg_state_o = 1'b1;
                    cnt_en         = 1'b1;
                    state_d        = AD_PERM;
                end
            end
            AD_PERM: begin
                en_reg_state_o = 1'b1;
                cnt_en         = 1'b1;
                if (round_last) begin
                    ad_cnt_d = ad_cnt_q - CNT_W'(1);
                    if (ad_last) begin
                        en_xor_lsb_o = 1'b1;
                        state_d      = PT_WAIT;
                        cnt_init_a   = pt_last;
                        cnt_init_b   = !pt_last;
                    end else begin
                        state_d    = AD_WAIT;
                        cnt_init_b = 1'b1;
                    end
                end
            end
            PT_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_o  = 1'b1;
                    en_cipher_o    = 1'b1;
                    en_reg_state_o = 1'b1;
                    cnt_en         = 1'b1;
                    pt_cnt_d       = pt_cnt_q - CNT_W'(1);
                    // Last block starts p^a directly, so the key enters before round 0.
                    if (pt_last) begin
                        en_xor_begin_key_o = 1'b1;
                        state_d            = FINAL;
                    end else begin
                        state_d = PT_PERM;
                    end
                end
            end
            PT_PERM: begin
                en_reg_state_o = 1'b1;
                cnt_en         = 1'b1;
                if (round_last) begin
                    state_d    = PT_WAIT;
                    cnt_init_a = pt_last;
                    cnt_init_b = !pt_last;
                end
            end
            FINAL: begin
                en_reg_state_o = 1'b1;
                cnt_en         = 1'b1;
                if (round_last) begin
                    en_xor_end_key_o = 1'b1;
                    state_d          = TAG;
                end
            end
            TAG: begin
                en_tag_o   = 1'b1;
                done_o     = 1'b1;
                cnt_init_a = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q  <= IDLE;
            ad_cnt_q <= '0;
            pt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ad_cnt_q <= ad_cnt_d;
            pt_cnt_q <= pt_cnt_d;
        end
    end

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Self-checking bench for ascon_fsm_ctrl: a per-cycle expected schedule is
// built from the phase/round rules and compared with the controller outputs.
module tb_ascon_fsm_ctrl;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic [3:0] nb_ad_i;
    logic [3:0] nb_pt_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       init_state_o, en_reg_state_o, en_xor_data_o, en_xor_begin_key_o;
    logic       en_xor_end_key_o, en_xor_lsb_o, en_cipher_o, en_tag_o, busy_o, done_o;

    ascon_fsm_ctrl dut (
        .clock_i            (clock_i),
        .resetb_i           (resetb_i),
        .start_i            (start_i),
        .nb_ad_i            (nb_ad_i),
        .nb_pt_i            (nb_pt_i),
        .data_valid_i       (data_valid_i),
        .data_ready_o       (data_ready_o),
        .round_o            (round_o),
        .init_state_o       (init_state_o),
        .en_reg_state_o     (en_reg_state_o),
        .en_xor_data_o      (en_xor_data_o),
        .en_xor_begin_key_o (en_xor_begin_key_o),
        .en_xor_end_key_o   (en_xor_end_key_o),
        .en_xor_lsb_o       (en_xor_lsb_o),
        .en_cipher_o        (en_cipher_o),
        .en_tag_o           (en_tag_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clock_i = ~clock_i;

    // {busy, done, tag, cipher, lsb, end_key, begin_key, xor_data, en_reg, init_state, ready, round}
    logic [14:0] obs;
    assign obs = {busy_o, done_o, en_tag_o, en_cipher_o, en_xor_lsb_o, en_xor_end_key_o,
                  en_xor_begin_key_o, en_xor_data_o, en_reg_state_o, init_state_o,
                  data_ready_o, round_o};

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] exp_q[$];
    logic [14:0] mask_q[$];
    bit          vld_q[$];
    int          stalls;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [14:0] mk(input bit busy, input bit done, input bit tag, input bit cipher,
                                       input bit lsb, input bit ek, input bit bk, input bit xd,
                                       input bit er, input bit is, input bit rdy, input int rnd);
        return {busy, done, tag, cipher, lsb, ek, bk, xd, er, is, rdy, 4'(rnd)};
    endfunction

    task automatic push(input logic [14:0] e, input logic [14:0] m, input bit v);
        exp_q.push_back(e);
        mask_q.push_back(m);
        vld_q.push_back(v);
    endtask

    // Valid is random wherever the controller is not waiting for a block.
    task automatic build(input int a, input int p_raw, input int fixed_pt_stall);
        int p;
        int s;
        bit last;
        p = (p_raw == 0) ? 1 : p_raw;
        exp_q.delete();
        mask_q.delete();
        vld_q.delete();
        stalls = 0;
        push(15'd0, 15'h7fff, 1'($urandom));
        for (int r = 0; r < 12; r++)
            push(mk(1, 0, 0, 0, (r == 11) && (a == 0), r == 11, 0, 0, 1, r == 0, 0, r), 15'h7fff, 1'($urandom));
        for (int b = 0; b < a; b++) begin
            s = (fixed_pt_stall >= 0) ? 0 : int'($urandom_range(0, 3));
            stalls += s;
            for (int k = 0; k < s; k++)
                push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6), 15'h7fff, 1'b0);
            push(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 6), 15'h7fff, 1'b1);
            for (int r = 7; r < 12; r++)
                push(mk(1, 0, 0, 0, (r == 11) && (b == a - 1), 0, 0, 0, 1, 0, 0, r), 15'h7fff, 1'($urandom));
        end
        for (int q = 0; q < p; q++) begin
            last = (q == p - 1);
            s = (fixed_pt_stall >= 0) ? fixed_pt_stall : int'($urandom_range(0, 3));
            stalls += s;
            for (int k = 0; k < s; k++)
                push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, last ? 0 : 6), 15'h7fff, 1'b0);
            push(mk(1, 0, 0, 1, 0, 0, last, 1, 1, 0, 1, last ? 0 : 6), 15'h7fff, 1'b1);
            if (!last)
                for (int r = 7; r < 12; r++)
                    push(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, r), 15'h7fff, 1'($urandom));
        end
        for (int r = 1; r < 12; r++)
            push(mk(1, 0, 0, 0, 0, r == 11, 0, 0, 1, 0, 0, r), 15'h7fff, 1'($urandom));
        push(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 15'h7ff0, 1'($urandom));
    endtask

    task automatic run_seq(input string name, input int a, input int p, input int fixed_pt_stall,
                           input int abort_at);
        int done_cyc;
        int pe;
        done_cyc = -1;
        pe = (p == 0) ? 1 : p;
        build(a, p, fixed_pt_stall);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clock_i);
            #1;
            if (c == 0) begin
                start_i = 1'b1;
                nb_ad_i = 4'(a);
                nb_pt_i = 4'(p);
            end else begin
                start_i = 1'($urandom);
                nb_ad_i = 4'($urandom);
                nb_pt_i = 4'($urandom);
            end
            data_valid_i = vld_q[c];
            #2;
            check_val($sformatf("%s c%0d", name, c), 32'(obs & mask_q[c]), 32'(exp_q[c] & mask_q[c]));
            if (done_o) done_cyc = c;
            if (c == abort_at) begin
                resetb_i = 1'b0;
                start_i  = 1'b0;
                #1;
                check_val({name, " async_rst"}, 32'(obs), 32'd0);
                @(posedge clock_i);
                #1;
                resetb_i = 1'b1;
                return;
            end
        end
        @(posedge clock_i);
        #1;
        start_i      = 1'b0;
        data_valid_i = 1'($urandom);
        #2;
        check_val({name, " idle_after"}, 32'(obs[14:13]), 32'd0);
        check_val({name, " latency"}, 32'(done_cyc), 32'(12 + 6 * a + 6 * (pe - 1) + 12 + 1 + stalls));
    endtask

    initial begin
        resetb_i     = 1'b0;
        start_i      = 1'b0;
        nb_ad_i      = 4'd0;
        nb_pt_i      = 4'd0;
        data_valid_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #3;
        check_val("reset_state", 32'(obs), 32'd0);
        @(posedge clock_i);
        #1;
        resetb_i = 1'b1;

        run_seq("ad1_pt1", 1, 1, 0, -1);
        run_seq("ad0_pt2", 0, 2, 0, -1);
        run_seq("pt_stall3", 1, 1, 3, -1);
        run_seq("abort_final", 1, 1, 0, 24);
        run_seq("after_abort", 1, 1, 0, -1);
        run_seq("pt_zero", 1, 0, 0, -1);
        for (int i = 0; i < 12; i++)
            run_seq($sformatf("rand%0d", i), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascon_fsm_ctrl.md
Name: ascon_fsm_ctrl

Overview:
Moore/Mealy controller that sequences the ASCON-128 encryption datapath. The datapath is:
- input XOR stage (data into x0, key into x1||x2)
- round-constant/substitution/diffusion round
- end-of-permutation key/domain-separation XOR
- 320-bit state register

The block drives one permutation round per clock and walks Initialisation, Associated Data, Plaintext, Finalisation and Tag. It handles the valid/ready handshake for 64-bit data blocks and tells the top level when ciphertext and tag words are valid.

Parameters:
ROUNDS_A, 12, rounds for p^a (initialisation, finalisation)
ROUNDS_B, 6, rounds for p^b (AD and PT blocks)
CNT_W, 4, width of block-count inputs and internal block counter

Ports:
clock_i  in  1  system clock
resetb_i  in  1  asynchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
nb_ad_i  in  CNT_W  number of padded AD blocks (0 allowed); sampled on start
nb_pt_i  in  CNT_W  number of padded PT blocks (>=1; 0 treated as 1); sampled on start
data_valid_i  in  1  data_i block present on datapath input
data_ready_o  out  1  controller can consume a block this cycle
round_o  out  4  round index to constant-add stage (0..11)
init_state_o  out  1  state mux selects IV||K||N instead of state register
en_reg_state_o  out  1  state register load enable
en_xor_data_o  out  1  XOR data_i into x0
en_xor_begin_key_o  out  1  XOR key into x1||x2 before round
en_xor_end_key_o  out  1  XOR 0^*||K into x3||x4 after round
en_xor_lsb_o  out  1  XOR 1 into LSB of x4 after round (domain separation)
en_cipher_o  out  1  x0 after input XOR is a valid ciphertext word
en_tag_o  out  1  x3||x4 of state register is the valid tag
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse with en_tag_o

Behaviour:
- Reset (async, any state): state=IDLE, round counter=0, block counter=0, all outputs 0.
- States: IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL, TAG.
- IDLE:
  - start_i=1 latches nb_ad_i and nb_pt_i, then goes to INIT with round=0.
  - start_i is ignored in every other state.
- INIT: round 0..11, en_reg_state_o=1 each cycle.
  - Round 0: init_state_o=1.
  - Round 11: en_xor_end_key_o=1; also en_xor_lsb_o=1 if nb_ad=0.
  - Next state: AD_WAIT if nb_ad>0, else PT_WAIT.
- AD_WAIT: data_ready_o=1.
  - The acceptance cycle (data_valid_i=1) is round 6 of p^b: en_xor_data_o=1, en_reg_state_o=1, then go to AD_PERM.
  - If data_valid_i=0: no load, round_o holds 6, stay in state.
- AD_PERM: rounds 7..11.
  - At round 11: decrement AD count.
  - If last AD block: en_xor_lsb_o=1 and go to PT_WAIT; otherwise go to AD_WAIT.
- PT_WAIT: data_ready_o=1. On acceptance: en_xor_data_o=1, en_cipher_o=1, en_reg_state_o=1.
  - Non-last block: round=6, go to PT_PERM (rounds 7..11, then back to PT_WAIT).
  - Last block: round=0 of p^a with en_xor_begin_key_o=1 in the same cycle, go to FINAL.
- FINAL: rounds 1..11; en_xor_end_key_o=1 at round 11; then go to TAG.
- TAG: one cycle with en_tag_o=1, done_o=1, en_reg_state_o=0; then go to IDLE.
- Round counter:
  - Increments by 1 per loaded round.
  - Preloads 0 for p^a and 6 for p^b.
  - Never wraps past 11.
- Enables are combinational from state, counter and data_valid_i (Mealy only on the handshake).
- Latency with valid always high: 12 + 6*A + 6*(P-1) + 12 + 1 cycles from the cycle after start to done.

Decomposition:
- ascon_pack holds the state enum type_fsm, the ROUND_A/ROUND_B constants and the IV constant.
- One sub-module, ascon_round_cnt: 4-bit counter with init_a_i (load 0), init_b_i (load 6), en_i, and round_o.
- The block counter stays inline.

Test Plan:
- Reset asserted mid-FINAL (round 5) -> outputs 0, busy_o=0 immediately; next start runs a full sequence.
- nb_ad=1, nb_pt=1, valid always high, start at cycle 0 -> expected outputs:
  - init_state_o at cycle 1; en_xor_end_key_o at cycle 12.
  - AD accepted at 13 with round_o=6; en_xor_lsb_o at 18.
  - PT accepted at 19 with en_cipher_o, en_xor_begin_key_o, round_o=0.
  - en_xor_end_key_o at 30; en_tag_o/done_o at 31.
- nb_ad=0, nb_pt=2 -> en_xor_end_key_o and en_xor_lsb_o both at cycle 12; PT rounds 13-18; final 19-30; tag 31.
- nb_ad=1, nb_pt=1, data_valid_i low for 3 cycles in PT_WAIT -> data_ready_o stays 1, en_reg_state_o=0, round_o=0; sequence resumes and tag shifts by 3 cycles.
- start_i pulsed during AD_PERM -> ignored; block counts unchanged; single done_o.
- nb_pt_i=0 -> behaves exactly as nb_pt_i=1.
